pipeline_id_ex: RTL
===================

Name: pipeline_id_ex

Overview:
ID/EX pipeline register with hazard control for the 5-stage MIPS pipeline.
- Captures decoded operands and control from ID.
- Inserts bubbles on load-use hazards and branch/jump flushes, and freezes on memory wait.
- Produces ForwardA/ForwardB select codes for the EX stage directly downstream (00 = register value, 01 = MEM/WB data, 10 = EX/MEM data).

Parameters:
- RA_ADDR, 5'd31: write-back register for link (RegDst=2'b10).
- XP_ADDR, 5'd26: write-back register for exception PC (RegDst=2'b11).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ID_BusA  in  32  operand A from register file (or shamt when ID_ALUSrc1=1)
- ID_BusB  in  32  operand B from register file (or immediate when ID_ALUSrc2=1)
- ID_RtData  in  32  raw rt register value (store data)
- ID_Rs, ID_Rt, ID_Rd  in  5 each  source/destination register numbers
- ID_ALUSrc1, ID_ALUSrc2  in  1 each  operand is non-register (no forwarding)
- ID_ALUFun  in  6  ALU function code
- ID_Sign  in  1  signed compare
- ID_RegDst  in  2  00 rd, 01 rt, 10 RA_ADDR, 11 XP_ADDR
- ID_RegWr, ID_MemRd, ID_MemWr  in  1 each  control
- ID_MemToReg  in  2  write-back source select
- ID_PC4  in  32  PC+4 of the ID instruction
- Flush  in  1  branch/jump taken in EX: kill the instruction in ID
- MEM_Wait  in  1  data memory not ready: freeze the whole pipe
- EXMEM_RegWr  in  1  write enable in EX/MEM
- EXMEM_WriteAddr  in  5  destination register in EX/MEM
- MEMWB_RegWr  in  1  write enable in MEM/WB
- MEMWB_WriteAddr  in  5  destination register in MEM/WB
- MEMWB_Data  in  32  write-back data in MEM/WB
- EX_BusA, EX_BusB, EX_RtData  out  32 each  registered operands
- EX_ALUFun  out  6
- EX_Sign  out  1
- EX_WriteAddr  out  5  resolved destination register
- EX_RegWr, EX_MemRd, EX_MemWr  out  1 each
- EX_MemToReg  out  2
- EX_PC4  out  32
- EX_Valid  out  1  0 = bubble
- ForwardA, ForwardB  out  2 each  combinational, from registered state
- Stall  out  1  combinational: hold PC and IF/ID this cycle

Behaviour:
- Reset (reset=0, async):
  - All registered outputs are 0 (bubble).
  - ForwardA/ForwardB = 00; Stall = 0.
- Per-edge update priority:
  1. MEM_Wait=1: hold all registers.
  2. Flush=1: load bubble.
  3. Load-use hazard: load bubble.
  4. Otherwise: load from ID.
- Bubble: EX_RegWr = EX_MemRd = EX_MemWr = EX_Valid = 0; EX_WriteAddr = 0; data fields don't-care (implementation clears to 0).
- Load-use hazard, registered-side test: EX_Valid & EX_MemRd & EX_WriteAddr≠0 & (EX_WriteAddr==ID_Rs & ~ID_ALUSrc1 | EX_WriteAddr==ID_Rt).
- Stall:
  - Stall = hazard & ~Flush & ~MEM_Wait.
  - Exactly one bubble per load-use; the next cycle the load sits in EX/MEM, so the hazard has cleared.
- WriteAddr resolved at load from ID_RegDst (rd / rt / RA_ADDR / XP_ADDR).
- WB-to-ID bypass at load:
  - If MEMWB_RegWr & MEMWB_WriteAddr≠0 & MEMWB_WriteAddr==ID_Rs & ~ID_ALUSrc1: EX_BusA ← MEMWB_Data.
  - Same test against ID_Rt: EX_BusB ← MEMWB_Data when ~ID_ALUSrc2.
  - Same test against ID_Rt: EX_RtData ← MEMWB_Data unconditionally.
- Registered source copies: EX_Rs and EX_Rt are held internally, with ALUSrc flags gating them.
- ForwardA, evaluated from registered state:
  - 10 if EXMEM_RegWr & EXMEM_WriteAddr≠0 & EXMEM_WriteAddr==EX_Rs & ~EX_ALUSrc1.
  - Else 01 if the same conditions hold on MEMWB.
  - Else 00.
- ForwardB: same rules on EX_Rt, gated by ~EX_ALUSrc2.
- EX_Valid=0 forces ForwardA = ForwardB = 00.
- Register $0 is never forwarded or bypassed.
- No arithmetic; all paths are pure muxing. Latency is one cycle ID→EX.

Test Plan:
- Reset then release, ID_RegWr=1, ID_Rd=8, RegDst=00, BusA=5, BusB=7 → after one edge: EX_Valid=1, EX_WriteAddr=8, EX_BusA=5, EX_BusB=7.
- lw $9 in EX, then ID add using rs=9 → Stall=1 for one cycle and bubble loaded (EX_RegWr=0). Next cycle, with EXMEM_WriteAddr=9 and EXMEM_RegWr=1 → Stall=0, ForwardA=10 once the add is loaded.
- EX has rs=4; EXMEM and MEMWB both write $4 → ForwardA=10. With only MEMWB writing $4 → ForwardA=01. With writes targeting $0 → ForwardA=00.
- MEMWB writes $3 with data 0xDEADBEEF while ID reads rt=3, ALUSrc2=0 → EX_BusB=0xDEADBEEF and EX_RtData=0xDEADBEEF. With ALUSrc2=1 → EX_BusB = ID immediate, EX_RtData still 0xDEADBEEF.
- Flush=1 together with a load-use hazard → bubble loaded, Stall=0. MEM_Wait=1 held for 3 cycles → outputs unchanged throughout and Stall=0.
- reset asserted mid-stream between clock edges → outputs clear to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pipeline_id_ex.sv
// ID/EX pipeline register for the 5-stage MIPS pipe.
// Bubbles on flush/load-use, freezes on memory wait, drives EX forwarding selects.
module pipeline_id_ex #(
  parameter logic [4:0] RA_ADDR = 5'd31,
  parameter logic [4:0] XP_ADDR = 5'd26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ID_BusA,
  input  logic [31:0] ID_BusB,
  input  logic [31:0] ID_RtData,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  ID_Rd,
  input  logic        ID_ALUSrc1,
  input  logic        ID_ALUSrc2,
  input  logic [5:0]  ID_ALUFun,
  input  logic        ID_Sign,
  input  logic [1:0]  ID_RegDst,
  input  logic        ID_RegWr,
  input  logic        ID_MemRd,
  input  logic        ID_MemWr,
  input  logic [1:0]  ID_MemToReg,
  input  logic [31:0] ID_PC4,
  input  logic        Flush,
  input  logic        MEM_Wait,
  input  logic        EXMEM_RegWr,
  input  logic [4:0]  EXMEM_WriteAddr,
  input  logic        MEMWB_RegWr,
  input  logic [4:0]  MEMWB_WriteAddr,
  input  logic [31:0] MEMWB_Data,
  output logic [31:0] EX_BusA,
  output logic [31:0] EX_BusB,
  output logic [31:0] EX_RtData,
  output logic [5:0]  EX_ALUFun,
  output logic        EX_Sign,
  output logic [4:0]  EX_WriteAddr,
  output logic        EX_RegWr,
  output logic        EX_MemRd,
  output logic        EX_MemWr,
  output logic [1:0]  EX_MemToReg,
  output logic [31:0] EX_PC4,
  output logic        EX_Valid,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        Stall
);

  typedef struct packed {
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [31:0] rt_data;
    logic [5:0]  alu_fun;
    logic        sign;
    logic [4:0]  wa;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_to_reg;
    logic [31:0] pc4;
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;
  id_ex_t ld;
  logic   hazard;
  logic   wb_rs;
  logic   wb_rt;
  logic   ex_rs;
  logic   ex_rt;
  logic   mw_rs;
  logic   mw_rt;

  always_comb begin
    hazard = q.valid & q.mem_rd & (q.wa != 5'd0)
           & (((q.wa == ID_Rs) & ~ID_ALUSrc1) | (q.wa == ID_Rt));
    wb_rs = MEMWB_RegWr & (MEMWB_WriteAddr != 5'd0)
          & (MEMWB_WriteAddr == ID_Rs);
    wb_rt = MEMWB_RegWr & (MEMWB_WriteAddr != 5'd0)
          & (MEMWB_WriteAddr == ID_Rt);
  end

  assign Stall = hazard & ~Flush & ~MEM_Wait;

  always_comb begin
    ld = '0;
    ld.bus_a = (wb_rs & ~ID_ALUSrc1) ? MEMWB_Data : ID_BusA;
    ld.bus_b = (wb_rt & ~ID_ALUSrc2) ? MEMWB_Data : ID_BusB;
    ld.rt_data = wb_rt ? MEMWB_Data : ID_RtData;
    ld.alu_fun = ID_ALUFun;
    ld.sign = ID_Sign;
    unique case (ID_RegDst)
      2'b00:   ld.wa = ID_Rd;
      2'b01:   ld.wa = ID_Rt;
      2'b10:   ld.wa = RA_ADDR;
      default: ld.wa = XP_ADDR;
    endcase
    ld.reg_wr = ID_RegWr;
    ld.mem_rd = ID_MemRd;
    ld.mem_wr = ID_MemWr;
    ld.mem_to_reg = ID_MemToReg;
    ld.pc4 = ID_PC4;
    ld.valid = 1'b1;
    // Non-register operands keep a zero source so they never match.
    ld.rs = ID_ALUSrc1 ? 5'd0 : ID_Rs;
    ld.rt = ID_ALUSrc2 ? 5'd0 : ID_Rt;
  end

  always_comb begin
    d = ld;
    if (MEM_Wait) d = q;
    else if (Flush | hazard) d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

  always_comb begin
    ex_rs = EXMEM_RegWr & (EXMEM_WriteAddr != 5'd0)
          & (EXMEM_WriteAddr == q.rs);
    ex_rt = EXMEM_RegWr & (EXMEM_WriteAddr != 5'd0)
          & (EXMEM_WriteAddr == q.rt);
    mw_rs = MEMWB_RegWr & (MEMWB_WriteAddr != 5'd0)
          & (MEMWB_WriteAddr == q.rs);
    mw_rt = MEMWB_RegWr & (MEMWB_WriteAddr != 5'd0)
          & (MEMWB_WriteAddr == q.rt);
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (q.valid) begin
      if (ex_rs)      ForwardA = 2'b10;
      else if (mw_rs) ForwardA = 2'b01;
      if (ex_rt)      ForwardB = 2'b10;
      else if (mw_rt) ForwardB = 2'b01;
    end
  end

  assign EX_BusA      = q.bus_a;
  assign EX_BusB      = q.bus_b;
  assign EX_RtData    = q.rt_data;
  assign EX_ALUFun    = q.alu_fun;
  assign EX_Sign      = q.sign;
  assign EX_WriteAddr = q.wa;
  assign EX_RegWr     = q.reg_wr;
  assign EX_MemRd     = q.mem_rd;
  assign EX_MemWr     = q.mem_wr;
  assign EX_MemToReg  = q.mem_to_reg;
  assign EX_PC4       = q.pc4;
  assign EX_Valid     = q.valid;

endmodule
